encoder_fifo_ip: RTL

ENCODER_FIFO_IP -- requirements
Module: encoder_fifo_ip

---
 rtl/clc_encoder_pkg.sv | 35 +++
 rtl/clc_encoder.sv | 59 +++++
 rtl/encoder_fifo_ip.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/clc_encoder_pkg.sv
// Shared definitions for the CLC encoder FIFO block.
// Holds the APB register offsets, STATUS/CTRL bit positions, data/codeword widths and the
// encode FSM state type.
package clc_encoder_pkg;

  localparam int unsigned DataW = 16;
  localparam int unsigned CwW   = 40;

  // Register offsets, decoded from PADDR[4:0]
  localparam logic [4:0] AddrDataIn = 5'h00;
  localparam logic [4:0] AddrCwLo   = 5'h04;
  localparam logic [4:0] AddrCwHi   = 5'h08;
  localparam logic [4:0] AddrStatus = 5'h0C;
  localparam logic [4:0] AddrCtrl   = 5'h10;

  // STATUS fields
  localparam int unsigned StatInCntLsb  = 0;
  localparam int unsigned StatOutCntLsb = 4;
  localparam int unsigned StatCntW      = 3;
  localparam int unsigned StatBusyBit   = 8;
  localparam int unsigned StatOvfBit    = 9;
  localparam int unsigned StatUdfBit    = 10;

  // CTRL fields
  localparam int unsigned CtrlEnableBit = 0;
  localparam int unsigned CtrlFlushBit  = 1;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StEncode,
    StStore
  } enc_state_e;

endpackage

// File: rtl/clc_encoder.sv
// Combinational CLC encoder: 16 data bits -> 40-bit codeword.
// Data is viewed as a 4x4 matrix, row r = data_i[4r+3:4r]. Codeword layout:
//   [15:0]  data
//   [27:16] Hamming(7,4) checks, 3 per row (row r at [16+3r +: 3])
//   [31:28] even parity of each row (4 data + 3 check bits)
//   [35:32] even parity of each data column
//   [38:36] even parity of each check-bit column
//   [39]    even parity over bits [38:0]
// Ports:
//   data_i  data word to encode
//   cw_o    codeword
module clc_encoder
  import clc_encoder_pkg::*;
(
  input  logic [DataW-1:0] data_i,
  output logic [CwW-1:0]   cw_o
);

  logic [11:0]    ham;
  logic [3:0]     row_par;
  logic [3:0]     col_par;
  logic [2:0]     ham_par;
  logic [CwW-2:0] body;

  // Hamming positions 3,5,6,7 carry d0..d3; check k covers positions with bit k set
  always_comb begin
    ham = '0;
    for (int r = 0; r < 4; r++) begin
      ham[3*r]   = data_i[4*r] ^ data_i[4*r+1] ^ data_i[4*r+3];
      ham[3*r+1] = data_i[4*r] ^ data_i[4*r+2] ^ data_i[4*r+3];
      ham[3*r+2] = data_i[4*r+1] ^ data_i[4*r+2] ^ data_i[4*r+3];
    end
  end

  always_comb begin
    row_par = '0;
    for (int r = 0; r < 4; r++) begin
      row_par[r] = ^{data_i[4*r +: 4], ham[3*r +: 3]};
    end
  end

  always_comb begin
    col_par = '0;
    for (int c = 0; c < 4; c++) begin
      col_par[c] = data_i[c] ^ data_i[c+4] ^ data_i[c+8] ^ data_i[c+12];
    end
  end

  always_comb begin
    ham_par = '0;
    for (int k = 0; k < 3; k++) begin
      ham_par[k] = ham[k] ^ ham[k+3] ^ ham[k+6] ^ ham[k+9];
    end
  end

  assign body = {ham_par, col_par, row_par, ham, data_i};
  assign cw_o = {^body, body};

endmodule

// File: rtl/encoder_fifo_ip.sv
// APB-attached CLC encoder with input and output FIFOs.
// Software pushes 16-bit words through DATA_IN; an IDLE/LOAD/ENCODE/STORE FSM moves them
// through clc_encoder into the output FIFO, read back as CW_LO then CW_HI (CW_HI pops).
// Ports:
//   PCLK, PRESETn                          clock, async active-low reset
//   PADDR, PWDATA, PSEL, PENABLE, PWRITE   APB request
//   PRDATA, PREADY, PSLVERR                APB response (PREADY tied high)
module encoder_fifo_ip
  import clc_encoder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  logic [4:0] addr;
  logic       setup_rd, wr_en, rd_acc;
  logic       din_wr, sts_wr, ctrl_wr, cwhi_acc, flush, start;
  logic       unused_bits;

  logic [DataW-1:0] in_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  in_wptr_q, in_rptr_q;
  logic [CntW-1:0]  in_cnt_q, in_cnt_d;
  logic             in_push, in_pop, in_full, in_empty;

  logic [CwW-1:0]   out_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  out_wptr_q, out_rptr_q;
  logic [CntW-1:0]  out_cnt_q, out_cnt_d;
  logic             out_push, out_pop, out_empty;
  logic [CwW-1:0]   out_head;

  enc_state_e       state_q;
  logic [DataW-1:0] data_q;
  logic [CwW-1:0]   cw_q, enc_cw;

  logic        enable_q, ovf_q, ovf_d, udf_q, udf_d, rd_empty_q;
  logic [31:0] prdata_q, rdata, status;

  assign addr        = PADDR[4:0];
  assign unused_bits = ^{PADDR[31:5], PWDATA[31:16]};

  assign setup_rd = PSEL & ~PENABLE & ~PWRITE;
  assign wr_en    = PSEL & PENABLE & PWRITE;
  assign rd_acc   = PSEL & PENABLE & ~PWRITE;
  assign din_wr   = wr_en & (addr == AddrDataIn);
  assign sts_wr   = wr_en & (addr == AddrStatus);
  assign ctrl_wr  = wr_en & (addr == AddrCtrl);
  assign cwhi_acc = rd_acc & (addr == AddrCwHi);
  assign flush    = ctrl_wr & PWDATA[CtrlFlushBit];

  assign in_full   = (in_cnt_q == DepthCnt);
  assign in_empty  = (in_cnt_q == '0);
  assign out_empty = (out_cnt_q == '0);
  assign out_head  = out_mem_q[out_rptr_q];

  // Nothing is in flight while idle, so output space reduces to out_count < depth
  assign start    = (state_q == StIdle) & enable_q & ~in_empty & (out_cnt_q < DepthCnt) & ~flush;
  assign in_pop   = start;
  assign in_push  = din_wr & (~in_full | in_pop);
  assign out_push = (state_q == StEncode) & ~flush;
  // Emptiness was latched at setup so the pop/error decision matches the data returned
  assign out_pop  = cwhi_acc & ~rd_empty_q;

  assign PREADY  = 1'b1;
  assign PSLVERR = (din_wr & in_full & ~in_pop) | (cwhi_acc & rd_empty_q);
  assign PRDATA  = prdata_q;

  always_comb begin
    in_cnt_d = in_cnt_q;
    if (flush) begin
      in_cnt_d = '0;
    end else if (in_push && !in_pop) begin
      in_cnt_d = in_cnt_q + CntW'(1);
    end else if (!in_push && in_pop) begin
      in_cnt_d = in_cnt_q - CntW'(1);
    end
  end

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (flush) begin
      out_cnt_d = '0;
    end else if (out_push && !out_pop) begin
      out_cnt_d = out_cnt_q + CntW'(1);
    end else if (!out_push && out_pop) begin
      out_cnt_d = out_cnt_q - CntW'(1);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and counts
  always_ff @(posedge PCLK) begin
    if (in_push) in_mem_q[in_wptr_q] <= PWDATA[DataW-1:0];
    if (out_push) out_mem_q[out_wptr_q] <= cw_q;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      in_wptr_q  <= '0;
      in_rptr_q  <= '0;
      in_cnt_q   <= '0;
      out_wptr_q <= '0;
      out_rptr_q <= '0;
      out_cnt_q  <= '0;
    end else begin
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      if (flush) begin
        in_wptr_q  <= '0;
        in_rptr_q  <= '0;
        out_wptr_q <= '0;
        out_rptr_q <= '0;
      end else begin
        if (in_push)  in_wptr_q  <= in_wptr_q + PtrW'(1);
        if (in_pop)   in_rptr_q  <= in_rptr_q + PtrW'(1);
        if (out_push) out_wptr_q <= out_wptr_q + PtrW'(1);
        if (out_pop)  out_rptr_q <= out_rptr_q + PtrW'(1);
      end
    end
  end

  clc_encoder u_enc (
    .data_i (data_q),
    .cw_o   (enc_cw)
  );

  // Each state's action happens on the edge that enters it
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= StIdle;
      data_q  <= '0;
      cw_q    <= '0;
    end else if (flush) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StLoad;
            data_q  <= in_mem_q[in_rptr_q];
          end
        end
        StLoad: begin
          state_q <= StEncode;
          cw_q    <= enc_cw;
        end
        StEncode: state_q <= StStore;
        StStore:  state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  // Set wins over a same-cycle write-1-to-clear
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (sts_wr && PWDATA[StatOvfBit]) ovf_d = 1'b0;
    if (sts_wr && PWDATA[StatUdfBit]) udf_d = 1'b0;
    if (din_wr && in_full && !in_pop) ovf_d = 1'b1;
    if (cwhi_acc && rd_empty_q) udf_d = 1'b1;
  end

  always_comb begin
    status = '0;
    status[StatInCntLsb +: StatCntW]  = StatCntW'(in_cnt_q);
    status[StatOutCntLsb +: StatCntW] = StatCntW'(out_cnt_q);
    status[StatBusyBit]               = (state_q != StIdle);
    status[StatOvfBit]                = ovf_q;
    status[StatUdfBit]                = udf_q;
  end

  always_comb begin
    rdata = '0;
    case (addr)
      AddrCwLo:   if (!out_empty) rdata = out_head[31:0];
      AddrCwHi:   if (!out_empty) rdata = 32'(out_head[CwW-1:32]);
      AddrStatus: rdata = status;
      AddrCtrl:   rdata[CtrlEnableBit] = enable_q;
      default:    ;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      enable_q   <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_empty_q <= 1'b0;
      prdata_q   <= '0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      if (ctrl_wr) enable_q <= PWDATA[CtrlEnableBit];
      if (setup_rd) begin
        prdata_q   <= rdata;
        rd_empty_q <= out_empty;
      end
    end
  end

endmodule
